// File: rtl/dice_roll_sequencer_if.sv
// Handshake and data bundle between the dice roll sequencer and its neighbours.
// Signal directions are named from the sequencer's point of view.
interface dice_roll_sequencer_if;
    logic        i_roll_req;
    logic        i_roll_ack;
    logic        i_seed_load;
    logic [15:0] i_seed_in;
    logic [2:0]  o_d1;
    logic [2:0]  o_d2;
    logic [2:0]  o_d3;
    logic [2:0]  o_d4;
    logic [2:0]  o_d5;
    logic [2:0]  o_d6;
    logic        o_roll_valid;
    logic        o_busy;
    logic [7:0]  o_roll_count;

    modport slave (
        input  i_roll_req,
        input  i_roll_ack,
        input  i_seed_load,
        input  i_seed_in,
        output o_d1,
        output o_d2,
        output o_d3,
        output o_d4,
        output o_d5,
        output o_d6,
        output o_roll_valid,
        output o_busy,
        output o_roll_count
    );

    modport master (
        output i_roll_req,
        output i_roll_ack,
        output i_seed_load,
        output i_seed_in,
        input  o_d1,
        input  o_d2,
        input  o_d3,
        input  o_d4,
        input  o_d5,
        input  o_d6,
        input  o_roll_valid,
        input  o_busy,
        input  o_roll_count
    );
endinterface

// File: rtl/dice_roll_sequencer.sv
// Produces one six-dice throw from a free-running 16-bit LFSR, rejecting codes 6/7,
// and holds the finished throw under a valid/ack handshake.
module dice_roll_sequencer #(
    parameter logic [15:0] Seed = 16'hACE1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    dice_roll_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRoll = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;
    logic [2:0]  r_idx;
    logic [2:0]  w_idx_nxt;
    logic [2:0]  r_dice [6];
    logic [2:0]  w_dice_nxt [6];
    logic [7:0]  r_count;
    logic [7:0]  w_count_nxt;

    logic        w_fb;
    logic [2:0]  w_cand;
    logic        w_accept;

    // Candidate is taken from the LFSR before this edge's update.
    assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_cand   = r_lfsr[2:0];
    assign w_accept = (w_cand < 3'd6);

    always_comb begin
        w_lfsr_nxt = {r_lfsr[14:0], w_fb};
        if (bus.i_seed_load) begin
            w_lfsr_nxt = (bus.i_seed_in == 16'h0000) ? Seed : bus.i_seed_in;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_count_nxt = r_count;
        w_dice_nxt  = r_dice;

        unique case (r_state)
            StIdle: begin
                if (bus.i_roll_req) begin
                    w_state_nxt = StRoll;
                    w_idx_nxt   = 3'd0;
                end
            end
            StRoll: begin
                if (w_accept) begin
                    for (int i = 0; i < 6; i++) begin
                        if (r_idx == 3'(i)) begin
                            w_dice_nxt[i] = w_cand;
                        end
                    end
                    if (r_idx == 3'd5) begin
                        w_state_nxt = StDone;
                        w_idx_nxt   = 3'd0;
                        w_count_nxt = r_count + 8'd1;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            StDone: begin
                // Ack together with a request chains straight into the next throw.
                if (bus.i_roll_ack) begin
                    w_state_nxt = bus.i_roll_req ? StRoll : StIdle;
                    w_idx_nxt   = 3'd0;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_idx_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_lfsr  <= Seed;
            r_idx   <= 3'd0;
            r_count <= 8'd0;
            for (int i = 0; i < 6; i++) begin
                r_dice[i] <= 3'd0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_idx   <= w_idx_nxt;
            r_count <= w_count_nxt;
            for (int i = 0; i < 6; i++) begin
                r_dice[i] <= w_dice_nxt[i];
            end
        end
    end

    assign bus.o_d1         = r_dice[0];
    assign bus.o_d2         = r_dice[1];
    assign bus.o_d3         = r_dice[2];
    assign bus.o_d4         = r_dice[3];
    assign bus.o_d5         = r_dice[4];
    assign bus.o_d6         = r_dice[5];
    assign bus.o_busy       = (r_state == StRoll);
    assign bus.o_roll_valid = (r_state == StDone);
    assign bus.o_roll_count = r_count;

endmodule
